uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions (states, line levels, baud constants) for the transmitter and receiver.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

    localparam int   CLKS_PER_BIT_115200 = 868;
    localparam int   UART_DATA_BITS      = 8;
    localparam logic LINE_IDLE           = 1'b1;
    localparam logic LINE_START          = 1'b0;
endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter: producer holds data_in/data_valid until ready is seen.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_in;
    logic                      data_valid;
    logic                      ready;

    modport master (output data_in, output data_valid, input ready);
    modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle tick at count CLKS_PER_BIT-1, held at 0 while clear is high.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int                CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (8E1/8O1 when UART_TX_PARITY_EN is defined); tx falls 1 clk after accept.
// ready stays low for the whole frame, so data_valid while busy is ignored and the producer holds.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       busy
);
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_tx_state_t            state_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [2:0]                bit_cnt_q;
    logic                      tx_q;
    logic                      ready_q;
    logic                      busy_q;
    logic                      tick;
    logic                      accept;

    assign accept    = bus.data_valid && ready_q;
    assign bus.ready = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= (^bus.data_in) ^ PARITY_ODD;
        end
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    // bit_cnt_q wraps 7->0 leaving DATA, then counts stop bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= LINE_IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q <= bus.data_in;
                        state_q <= START;
                        tx_q    <= LINE_START;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= LINE_IDLE;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state_q <= STOP;
                        tx_q    <= LINE_IDLE;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (bit_cnt_q == STOP_LAST) begin
                            state_q   <= IDLE;
                            bit_cnt_q <= '0;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bit_cnt_q <= '0;
                    tx_q      <= LINE_IDLE;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: a fast instance (4 clk/bit) and a 868 clk/bit instance, each watched by a line receiver.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
    localparam int STOPB = 2;
`else
    localparam int PBITS = 0;
    localparam int STOPB = 1;
`endif
    localparam int  NF   = 4;
    localparam int  NS   = 868;
    localparam int  FB   = 1 + 8 + PBITS + STOPB;
    localparam bit  PODD = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx, busy, tx_s, busy_s;

    always #5 clk = ~clk;

    uart_tx_if bus ();
    uart_tx_if bus_s ();

    uart_tx #(.CLKS_PER_BIT(NF), .STOP_BITS(STOPB), .PARITY_ODD(PODD)) dut (
        .clk (clk), .rst (rst), .bus (bus), .tx (tx), .busy (busy)
    );
    uart_tx #(.CLKS_PER_BIT(NS), .STOP_BITS(STOPB), .PARITY_ODD(PODD)) dut_s (
        .clk (clk), .rst (rst), .bus (bus_s), .tx (tx_s), .busy (busy_s)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [FB-1:0] frame_bits(input logic [7:0] b);
        logic [FB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (PBITS == 1) f[9] = (^b) ^ PODD;
        return f;
    endfunction

    // Reference receiver: every sample of every bit must match the expected level; data decoded at mid-bit.
    task automatic monitor(input int sel, input int n);
        logic [FB-1:0] bits;
        logic [7:0]    exp_b, got_b;
        logic          lvl;
        bit            active;
        int            bitn, cyc, bad;
        active = 0; bitn = 0; cyc = 0; bad = 0; bits = '1; exp_b = '0; got_b = '0;
        forever begin
            @(negedge clk);
            lvl = (sel == 0) ? tx : tx_s;
            if (rst) begin
                active = 0;
            end else begin
                if (!active && lvl == 1'b0) begin
                    checks++;
                    if ((sel == 0 ? q0.size() : q1.size()) == 0) begin
                        errors++;
                        $display("FAIL unexpected_start_%0d: got a start bit, expected none", sel);
                        exp_b = '0;
                    end else begin
                        exp_b = (sel == 0) ? q0.pop_front() : q1.pop_front();
                    end
                    bits = frame_bits(exp_b);
                    active = 1; bitn = 0; cyc = 0; bad = 0; got_b = '0;
                end
                if (active) begin
                    if (lvl !== bits[bitn]) bad++;
                    if (cyc == n / 2 && bitn >= 1 && bitn <= 8) got_b[bitn-1] = lvl;
                    cyc++;
                    if (cyc == n) begin
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL line%0d_byte%02h_bit%0d: %0d of %0d samples wrong, expected level %0b",
                                     sel, exp_b, bitn, bad, n, bits[bitn]);
                        end
                        bitn++; cyc = 0; bad = 0;
                        if (bitn == FB) begin
                            chk($sformatf("decode%0d", sel), {24'd0, got_b}, {24'd0, exp_b});
                            active = 0;
                        end
                    end
                end
            end
        end
    endtask

    initial monitor(0, NF);
    initial monitor(1, NS);

    // Called at a negedge; returns #1 after the accept edge.
    task automatic accept(input logic [7:0] b);
        int w;
        w = 0;
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        while (!bus.ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        q0.push_back(b);
        #1;
        chk("ready_low_after_accept", bus.ready, 0);
        chk("busy_high_after_accept", busy, 1);
    endtask

    // Counts negedges with ready low; ends at the negedge where ready is back.
    task automatic wait_frame(input bit drop, input int sw_at, input logic [7:0] sw_dat, output int cnt);
        cnt = 0;
        @(negedge clk);
        if (drop) bus.data_valid = 1'b0;
        while (!bus.ready && cnt < 5000) begin
            cnt++;
            if (cnt == sw_at) bus.data_in = sw_dat;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        bus.data_in = '0; bus.data_valid = 1'b0;
        bus_s.data_in = '0; bus_s.data_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_tx", tx, 1);
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tx_slow", tx_s, 1);
        @(negedge clk);
        rst = 1'b0;

        // 0x55 single frame
        accept(8'h55);
        chk("tx_falls_after_accept", tx, 0);
        wait_frame(1, -1, 8'h00, cnt);
        chk("frame_len_55", cnt, FB * NF);

        // 0xA5 with FF driven mid-frame, then 0x3C with valid held: ignored while busy, one idle cycle gap
        @(negedge clk);
        accept(8'hA5);
        bus.data_in = 8'hFF;
        wait_frame(0, FB * NF - 5, 8'h3C, cnt);
        chk("ready_held_low_A5", cnt, FB * NF);
        chk("gap_idle_tx", tx, 1);
        accept(8'h3C);
        chk("gap_then_start_tx", tx, 0);
        wait_frame(1, -1, 8'h00, cnt);
        chk("frame_len_3C", cnt, FB * NF);

        // reset during data bit 3 of 0x00, then a clean 0x81
        @(negedge clk);
        accept(8'h00);
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        chk("tx_low_before_rst", tx, 0);
        rst = 1'b1;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_ready", bus.ready, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        accept(8'h81);
        wait_frame(1, -1, 8'h00, cnt);
        chk("frame_len_81", cnt, FB * NF);

`ifdef UART_TX_PARITY_EN
        // even parity, two stop bits: 0x07 has parity 1, 12-bit frame
        @(negedge clk);
        accept(8'h07);
        wait_frame(1, -1, 8'h00, cnt);
        chk("frame_len_07", cnt, 48);
`endif

        // full-rate instance, 0x41
        @(negedge clk);
        bus_s.data_in    = 8'h41;
        bus_s.data_valid = 1'b1;
        @(posedge clk);
        q1.push_back(8'h41);
        #1;
        chk("slow_ready_low", bus_s.ready, 0);
        chk("slow_busy_high", busy_s, 1);
        @(negedge clk);
        bus_s.data_valid = 1'b0;
        cnt = 1;
        while (!bus_s.ready && cnt < 20000) begin
            @(negedge clk);
            if (!bus_s.ready) cnt++;
        end
        chk("slow_frame_len", cnt, FB * NS);

        repeat (3) @(negedge clk);
        chk("fast_queue_drained", q0.size(), 0);
        chk("slow_queue_drained", q1.size(), 0);
        chk("idle_tx_end", tx, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
